// File: rtl/instr_fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module : instr_fetch_unit_pkg
// Brief  : Shared fetch constants and the fetch FSM state type.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package instr_fetch_unit_pkg;

  localparam logic [31:0] c_NOP_INSTR = 32'hE320_F000;
  localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    RUN        = 2'd1,
    SKID       = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module : instr_fetch_unit_if
// Brief  : Fetch-stage bundle: control in, imem port, and decode-facing outputs.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if;
  logic        sel_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        branch_out;
  logic        epoch;

  modport master (
    input  sel_stall, branch_taken, branch_target, imem_rdata,
    output imem_en, imem_addr, instr_out, instr_valid, branch_out, epoch
  );

  modport slave (
    output sel_stall, branch_taken, branch_target, imem_rdata,
    input  imem_en, imem_addr, instr_out, instr_valid, branch_out, epoch
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_skid_buf.sv
//------------------------------------------------------------------------------
// Module : fetch_skid_buf
// Brief  : One-entry holding register for a returned word plus its epoch tag.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_skid_buf (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_load,
  input  wire logic        i_flush,
  input  wire logic [32:0] i_data,
  output logic [32:0]      o_data,
  output logic             o_full
);

  logic [32:0] r_data;
  logic        r_full;

  // Flush wins over load so a redirect never leaves a stale word behind.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module : instr_fetch_unit
// Brief  : PC/epoch tracking fetch stage with one-entry skid; optional perf
//          counters enabled by FETCH_PERF_CNT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = c_RESET_PC,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  wire logic           clk,
  input  wire logic           rst,
  instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [15:0]         redirect_count
`endif
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc;
  logic         r_epoch;
  logic         r_pend;
  logic         r_pend_tag;
  logic [31:0]  w_addr;
  logic         w_en;
  logic         w_epoch_nxt;
  logic         w_skid_load;
  logic         w_skid_flush;
  logic         w_skid_full;
  logic [32:0]  w_skid_q;
  logic         w_unused_tgt;

  assign w_addr       = bus.branch_taken ? {bus.branch_target[31:2], 2'b00} : r_pc;
  assign w_en         = !rst && !bus.sel_stall;
  assign w_epoch_nxt  = r_epoch ^ bus.branch_taken;
  assign w_unused_tgt = ^bus.branch_target[1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_skid_load  = 1'b0;
    w_skid_flush = bus.branch_taken;
    case (r_state)
      RESET_WAIT: w_state_nxt = RUN;
      RUN: begin
        // A word returning into a redirect is already stale, so it is dropped.
        if (r_pend && bus.sel_stall && !bus.branch_taken) begin
          w_skid_load = 1'b1;
          w_state_nxt = SKID;
        end
      end
      SKID: begin
        if (!bus.sel_stall || bus.branch_taken) begin
          w_skid_flush = 1'b1;
          w_state_nxt  = RUN;
        end
      end
      default: w_state_nxt = RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RESET_WAIT;
      r_pc       <= RESET_PC;
      r_epoch    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_tag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_en ? (w_addr + 32'd4) : w_addr;
      r_epoch    <= w_epoch_nxt;
      r_pend     <= w_en;
      r_pend_tag <= w_epoch_nxt;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_flush (w_skid_flush),
    .i_data  ({r_pend_tag, bus.imem_rdata}),
    .o_data  (w_skid_q),
    .o_full  (w_skid_full)
  );

  always_comb begin
    bus.imem_en     = w_en;
    bus.imem_addr   = w_addr;
    bus.epoch       = r_epoch;
    bus.instr_out   = NOP_INSTR;
    bus.instr_valid = 1'b0;
    bus.branch_out  = r_epoch;
    if (rst) begin
      bus.branch_out = 1'b0;
    end else if (w_skid_full) begin
      bus.instr_out   = w_skid_q[31:0];
      bus.branch_out  = w_skid_q[32];
      bus.instr_valid = 1'b1;
    end else if (r_pend) begin
      bus.instr_out   = bus.imem_rdata;
      bus.branch_out  = r_pend_tag;
      bus.instr_valid = 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_redir_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if (w_en && (r_fetch_cnt != '1))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (bus.branch_taken && (r_redir_cnt != '1))
        r_redir_cnt <= r_redir_cnt + 16'd1;
    end
  end

  assign fetch_count    = r_fetch_cnt;
  assign redirect_count = r_redir_cnt;
`endif

endmodule

`default_nettype wire
